// File: rtl/calc_key_sequencer_if.sv
// Keypad token channel between the keypad scanner and the calculator key sequencer.
// The master drives tokens and the slave returns key_ready.
interface calc_key_sequencer_if;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;

    modport master (output key_valid, output key_code, input key_ready);
    modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/calc_key_sequencer.sv
// Keypad-to-ALU control stage: builds decimal operands, runs a one-cycle ALU execute and latches the result.
// Optional macro CALC_CHAIN_EN: an operator typed while entering B executes and chains into the next operation.
module calc_key_sequencer #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_key_sequencer_if.slave  key_if,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    output logic [WIDTH-1:0]     disp_val,
    output logic                 zero_flag,
    output logic                 err,
    output logic                 done
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int EW = WIDTH + 4;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_OP_WAIT = 3'd1,
        S_ENTER_B = 3'd2,
        S_EXEC    = 3'd3,
        S_RESULT  = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, disp_q, disp_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             zf_q, zf_d, err_q, err_d, done_q, done_d, ready_q, ready_d;
`ifdef CALC_CHAIN_EN
    logic [2:0]       pend_op_q, pend_op_d;
    logic             chain_q, chain_d;
`endif

    logic             accept_s, is_digit_s, is_op_s, is_eq_s, is_clr_s;
    logic [EW-1:0]    a_app_s, b_app_s;
    logic             a_full_s, b_full_s;

    // operand*10 + digit, widened so the overflow test sees the true value
    function automatic logic [EW-1:0] append_digit(input logic [WIDTH-1:0] v, input logic [3:0] d);
        logic [EW-1:0] v_ext;
        v_ext = {4'd0, v};
        return (v_ext << 3) + (v_ext << 1) + {{(EW-4){1'b0}}, d};
    endfunction

    function automatic logic overflows(input logic [EW-1:0] v);
        return (v[EW-1:WIDTH] != 4'd0);
    endfunction

    assign accept_s   = key_if.key_valid && ready_q;
    assign is_digit_s = (key_if.key_code <= 5'd9);
    assign is_op_s    = (key_if.key_code[4:3] == 2'b10);
    assign is_eq_s    = (key_if.key_code == 5'h18);
    assign is_clr_s   = (key_if.key_code == 5'h19);
    assign a_app_s    = append_digit(a_q, key_if.key_code[3:0]);
    assign b_app_s    = append_digit(b_q, key_if.key_code[3:0]);
    assign a_full_s   = (cnt_a_q == CW'(MAX_DIGITS));
    assign b_full_s   = (cnt_b_q == CW'(MAX_DIGITS));

    // Next-state and next-output computation
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        op_d     = op_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        zf_d     = zf_q;
        done_d   = 1'b0;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        disp_d   = disp_q;
`ifdef CALC_CHAIN_EN
        pend_op_d = pend_op_q;
        chain_d   = chain_q;
`endif
        if (accept_s && is_clr_s) begin
            state_d  = S_ENTER_A;
            a_d      = '0;
            b_d      = '0;
            acc_d    = '0;
            op_d     = 3'd0;
            cnt_a_d  = '0;
            cnt_b_d  = '0;
            zf_d     = 1'b0;
            alu_a_d  = '0;
            alu_b_d  = '0;
            alu_op_d = 3'd0;
`ifdef CALC_CHAIN_EN
            pend_op_d = 3'd0;
            chain_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (accept_s && is_digit_s && !a_full_s) begin
                        if (overflows(a_app_s)) begin
                            state_d = S_ERROR;
                        end else begin
                            a_d     = a_app_s[WIDTH-1:0];
                            cnt_a_d = cnt_a_q + CW'(1);
                        end
                    end else if (accept_s && is_op_s) begin
                        op_d    = key_if.key_code[2:0];
                        state_d = S_OP_WAIT;
                    end else begin
                        state_d = S_ENTER_A;
                    end
                end
                S_OP_WAIT: begin
                    if (accept_s && is_digit_s) begin
                        b_d     = {{(WIDTH-4){1'b0}}, key_if.key_code[3:0]};
                        cnt_b_d = CW'(1);
                        state_d = S_ENTER_B;
                    end else if (accept_s && is_op_s) begin
                        op_d = key_if.key_code[2:0];
                    end else begin
                        state_d = S_OP_WAIT;
                    end
                end
                S_ENTER_B: begin
                    if (accept_s && is_digit_s && !b_full_s) begin
                        if (overflows(b_app_s)) begin
                            state_d = S_ERROR;
                        end else begin
                            b_d     = b_app_s[WIDTH-1:0];
                            cnt_b_d = cnt_b_q + CW'(1);
                        end
                    end else if (accept_s && is_eq_s) begin
                        state_d = S_EXEC;
`ifdef CALC_CHAIN_EN
                    end else if (accept_s && is_op_s) begin
                        pend_op_d = key_if.key_code[2:0];
                        chain_d   = 1'b1;
                        state_d   = S_EXEC;
`endif
                    end else begin
                        state_d = S_ENTER_B;
                    end
                end
                S_EXEC: begin
                    acc_d   = alu_result;
                    zf_d    = alu_zero;
                    done_d  = 1'b1;
                    state_d = S_RESULT;
`ifdef CALC_CHAIN_EN
                    if (chain_q) begin
                        a_d     = alu_result;
                        op_d    = pend_op_q;
                        b_d     = '0;
                        cnt_b_d = '0;
                        chain_d = 1'b0;
                        state_d = S_OP_WAIT;
                    end else begin
                        chain_d = 1'b0;
                    end
`endif
                end
                S_RESULT: begin
                    if (accept_s && is_digit_s) begin
                        a_d     = {{(WIDTH-4){1'b0}}, key_if.key_code[3:0]};
                        b_d     = '0;
                        cnt_a_d = CW'(1);
                        cnt_b_d = '0;
                        state_d = S_ENTER_A;
                    end else if (accept_s && is_op_s) begin
                        a_d     = acc_q;
                        op_d    = key_if.key_code[2:0];
                        cnt_b_d = '0;
                        state_d = S_OP_WAIT;
                    end else begin
                        state_d = S_RESULT;
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_ERROR;
                end
            endcase
        end

        // ALU drive is captured on entry to EXEC so it is stable for the whole cycle
        if (state_d == S_EXEC) begin
            alu_a_d  = a_d;
            alu_b_d  = b_d;
            alu_op_d = op_d;
        end else begin
            alu_op_d = alu_op_d;
        end

        case (state_d)
            S_ENTER_A, S_OP_WAIT: disp_d = a_d;
            S_ENTER_B:            disp_d = b_d;
            S_RESULT:             disp_d = acc_d;
            S_EXEC:               disp_d = disp_q;
            S_ERROR:              disp_d = '0;
            default:              disp_d = '0;
        endcase

        err_d   = (state_d == S_ERROR);
        ready_d = (state_d != S_EXEC);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_ENTER_A;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            op_q     <= 3'd0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            zf_q     <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 3'd0;
            disp_q   <= '0;
`ifdef CALC_CHAIN_EN
            pend_op_q <= 3'd0;
            chain_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            zf_q     <= zf_d;
            err_q    <= err_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            disp_q   <= disp_d;
`ifdef CALC_CHAIN_EN
            pend_op_q <= pend_op_d;
            chain_q   <= chain_d;
`endif
        end
    end

    assign key_if.key_ready = ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign disp_val  = disp_q;
    assign zero_flag = zf_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule
